// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating stall counter.
// Latency: one cycle ID->EX. Backpressure: stall is combinational and holds PC/IF-ID for one bubble.
`timescale 1ns/1ps
module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_dest,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_ALUSrc,
  input  logic [1:0]        id_MemtoReg,
  input  logic [3:0]        id_ALUOp,
  input  logic              flush,
  output logic              ex_valid,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_ALUSrc,
  output logic [1:0]        ex_MemtoReg,
  output logic [3:0]        ex_ALUOp,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dest,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic              stall,
  output logic [15:0]       hazard_count
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              alu_src;
    logic [1:0]        mem_to_reg;
    logic [3:0]        alu_op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        dest;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
  } ex_t;

  ex_t         ex_q, ex_d;
  logic [15:0] cnt_q, cnt_d;
  logic        hazard;
  logic        rs_hit, rt_hit;

  // A load in EX whose result ID needs cannot be forwarded yet.
  assign rs_hit = id_use_rs && (id_rs == ex_q.dest);
  assign rt_hit = id_use_rt && (id_rt == ex_q.dest);
  assign hazard = id_valid && ex_q.valid && ex_q.mem_read &&
                  (ex_q.dest != 5'd0) && (rs_hit || rt_hit);
  assign stall  = hazard && !flush;

  always_comb begin
    ex_d = '0;
    if (!flush && !hazard) begin
      ex_d.valid      = id_valid;
      ex_d.reg_write  = id_RegWrite && id_valid && (id_dest != 5'd0);
      ex_d.mem_read   = id_MemRead && id_valid;
      ex_d.mem_write  = id_MemWrite && id_valid;
      ex_d.alu_src    = id_ALUSrc;
      ex_d.mem_to_reg = id_MemtoReg;
      ex_d.alu_op     = id_ALUOp;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
      ex_d.dest       = id_dest;
      ex_d.pc4        = id_pc4;
      ex_d.rd1        = id_rd1;
      ex_d.rd2        = id_rd2;
      ex_d.imm        = id_imm;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_RegWrite  = ex_q.reg_write;
  assign ex_MemRead   = ex_q.mem_read;
  assign ex_MemWrite  = ex_q.mem_write;
  assign ex_ALUSrc    = ex_q.alu_src;
  assign ex_MemtoReg  = ex_q.mem_to_reg;
  assign ex_ALUOp     = ex_q.alu_op;
  assign ex_rs        = ex_q.rs;
  assign ex_rt        = ex_q.rt;
  assign ex_dest      = ex_q.dest;
  assign ex_pc4       = ex_q.pc4;
  assign ex_rd1       = ex_q.rd1;
  assign ex_rd2       = ex_q.rd2;
  assign ex_imm       = ex_q.imm;
  assign hazard_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: pipeline load, hazard stall, flush priority, reset and counter saturation.
`timescale 1ns/1ps
module tb_id_ex_stage;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [DATA_W-1:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [4:0]        id_rs, id_rt, id_dest;
  logic              id_use_rs, id_use_rt;
  logic              id_RegWrite, id_MemRead, id_MemWrite, id_ALUSrc;
  logic [1:0]        id_MemtoReg;
  logic [3:0]        id_ALUOp;
  logic              flush;
  logic              ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc;
  logic [1:0]        ex_MemtoReg;
  logic [3:0]        ex_ALUOp;
  logic [4:0]        ex_rs, ex_rt, ex_dest;
  logic [DATA_W-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic              stall;
  logic [15:0]       hazard_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg), .id_ALUOp(id_ALUOp),
    .flush(flush),
    .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg),
    .ex_ALUOp(ex_ALUOp), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .stall(stall), .hazard_count(hazard_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 0; id_pc4 = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_dest = '0; id_use_rs = 0; id_use_rt = 0;
    id_RegWrite = 0; id_MemRead = 0; id_MemWrite = 0; id_ALUSrc = 0;
    id_MemtoReg = '0; id_ALUOp = '0; flush = 0;
  endtask

  task automatic drive_lw(input logic [4:0] dest);
    clear_id();
    id_valid = 1; id_MemRead = 1; id_RegWrite = 1; id_dest = dest;
    id_MemtoReg = 2'b01; id_ALUSrc = 1;
  endtask

  task automatic drive_user(input logic [4:0] rs, input logic [4:0] dest);
    clear_id();
    id_valid = 1; id_rs = rs; id_use_rs = 1; id_rt = 5'd2; id_use_rt = 1;
    id_dest = dest; id_RegWrite = 1;
  endtask

  task automatic test_reset();
    clear_id();
    rst_n = 0;
    #12;
    tests_run++;
    if (ex_valid !== 1'b0 || hazard_count !== 16'd0 || stall !== 1'b0 || ex_dest !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset: valid=%b cnt=%h stall=%b dest=%0d, want 0 0 0 0", ex_valid, hazard_count, stall, ex_dest);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_normal();
    clear_id();
    id_valid = 1; id_dest = 5'd8; id_RegWrite = 1; id_rd1 = 32'h1234;
    id_rd2 = 32'hBEEF; id_imm = 32'hFFFF_FFF0; id_pc4 = 32'h0000_0104;
    id_rs = 5'd3; id_rt = 5'd4; id_ALUOp = 4'h2; id_MemtoReg = 2'b10; id_ALUSrc = 1;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++; $display("FAIL normal_stall: got %b want 0", stall);
    end
    tick();
    tests_run++;
    if (ex_valid !== 1 || ex_dest !== 5'd8 || ex_RegWrite !== 1 || ex_rd1 !== 32'h1234) begin
      tests_failed++;
      $display("FAIL normal_core: valid=%b dest=%0d rw=%b rd1=%h want 1 8 1 1234", ex_valid, ex_dest, ex_RegWrite, ex_rd1);
    end
    tests_run++;
    if (ex_rd2 !== 32'hBEEF || ex_imm !== 32'hFFFF_FFF0 || ex_pc4 !== 32'h104 || ex_rs !== 5'd3 ||
        ex_rt !== 5'd4 || ex_ALUOp !== 4'h2 || ex_MemtoReg !== 2'b10 || ex_ALUSrc !== 1 ||
        ex_MemRead !== 0 || ex_MemWrite !== 0) begin
      tests_failed++;
      $display("FAIL normal_fields: rd2=%h imm=%h pc4=%h rs=%0d rt=%0d op=%h m2r=%b src=%b mr=%b mw=%b want beef fffffff0 104 3 4 2 10 1 0 0",
               ex_rd2, ex_imm, ex_pc4, ex_rs, ex_rt, ex_ALUOp, ex_MemtoReg, ex_ALUSrc, ex_MemRead, ex_MemWrite);
    end
  endtask

  task automatic test_regzero();
    clear_id();
    id_valid = 1; id_dest = 5'd0; id_RegWrite = 1;
    tick();
    tests_run++;
    if (ex_RegWrite !== 0 || ex_valid !== 1) begin
      tests_failed++; $display("FAIL regzero: rw=%b valid=%b want 0 1", ex_RegWrite, ex_valid);
    end
    clear_id();
    id_valid = 0; id_dest = 5'd7; id_RegWrite = 1; id_MemRead = 1; id_MemWrite = 1; id_rd1 = 32'h55;
    tick();
    tests_run++;
    if (ex_valid !== 0 || ex_RegWrite !== 0 || ex_MemRead !== 0 || ex_MemWrite !== 0 || ex_rd1 !== 32'h55) begin
      tests_failed++;
      $display("FAIL invalid_ctrl: valid=%b rw=%b mr=%b mw=%b rd1=%h want 0 0 0 0 55", ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_rd1);
    end
  endtask

  task automatic test_load_use();
    drive_lw(5'd9);
    tick();
    drive_user(5'd9, 5'd10);
    #1;
    tests_run++;
    if (stall !== 1) begin
      tests_failed++; $display("FAIL loaduse_stall: got %b want 1", stall);
    end
    tick();
    tests_run++;
    if (ex_valid !== 0 || ex_dest !== 0 || ex_MemRead !== 0 || hazard_count !== 16'd1 || stall !== 0) begin
      tests_failed++;
      $display("FAIL loaduse_bubble: valid=%b dest=%0d mr=%b cnt=%0d stall=%b want 0 0 0 1 0", ex_valid, ex_dest, ex_MemRead, hazard_count, stall);
    end
    tick();
    tests_run++;
    if (ex_valid !== 1 || ex_dest !== 5'd10 || ex_rs !== 5'd9 || stall !== 0 || hazard_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL loaduse_resume: valid=%b dest=%0d rs=%0d stall=%b cnt=%0d want 1 10 9 0 1", ex_valid, ex_dest, ex_rs, stall, hazard_count);
    end
  endtask

  task automatic test_no_false_hazard();
    drive_lw(5'd0);
    tick();
    drive_user(5'd0, 5'd11);
    #1;
    tests_run++;
    if (stall !== 0) begin
      tests_failed++; $display("FAIL nohaz_r0: stall=%b want 0", stall);
    end
    drive_lw(5'd9);
    tick();
    clear_id();
    id_valid = 1; id_rs = 5'd3; id_use_rs = 1; id_rt = 5'd9; id_use_rt = 0;
    #1;
    tests_run++;
    if (stall !== 0) begin
      tests_failed++; $display("FAIL nohaz_unused_rt: stall=%b want 0", stall);
    end
    id_use_rt = 1;
    #1;
    tests_run++;
    if (stall !== 1) begin
      tests_failed++; $display("FAIL haz_rt: stall=%b want 1", stall);
    end
    id_valid = 0;
    #1;
    tests_run++;
    if (stall !== 0) begin
      tests_failed++; $display("FAIL nohaz_idle: stall=%b want 0", stall);
    end
    tick();
    tests_run++;
    if (hazard_count !== 16'd1) begin
      tests_failed++; $display("FAIL nohaz_count: cnt=%0d want 1", hazard_count);
    end
  endtask

  task automatic test_flush();
    drive_lw(5'd9);
    tick();
    drive_user(5'd9, 5'd12);
    id_rd1 = 32'hABCD;
    flush = 1;
    #1;
    tests_run++;
    if (stall !== 0) begin
      tests_failed++; $display("FAIL flush_stall: stall=%b want 0", stall);
    end
    tick();
    tests_run++;
    if (ex_valid !== 0 || ex_dest !== 0 || ex_rs !== 0 || ex_rd1 !== 0 || ex_RegWrite !== 0 || hazard_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL flush_haz_bubble: valid=%b dest=%0d rs=%0d rd1=%h rw=%b cnt=%0d want 0 0 0 0 0 1",
               ex_valid, ex_dest, ex_rs, ex_rd1, ex_RegWrite, hazard_count);
    end
    drive_user(5'd4, 5'd13);
    id_imm = 32'h77; flush = 1;
    tick();
    tests_run++;
    if (ex_valid !== 0 || ex_dest !== 0 || ex_imm !== 0 || hazard_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL flush_plain: valid=%b dest=%0d imm=%h cnt=%0d want 0 0 0 1", ex_valid, ex_dest, ex_imm, hazard_count);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 2; k++) begin
      drive_lw(5'd9);
      tick();
      drive_user(5'd9, 5'd10);
      tick();
    end
    drive_user(5'd5, 5'd14);
    tick();
    tests_run++;
    if (hazard_count !== 16'd3 || ex_valid !== 1) begin
      tests_failed++; $display("FAIL pre_reset: cnt=%0d valid=%b want 3 1", hazard_count, ex_valid);
    end
    #2 rst_n = 0;
    #1;
    tests_run++;
    if (ex_valid !== 0 || hazard_count !== 0 || ex_dest !== 0 || ex_RegWrite !== 0 || stall !== 0) begin
      tests_failed++;
      $display("FAIL async_reset: valid=%b cnt=%0d dest=%0d rw=%b stall=%b want 0 0 0 0 0", ex_valid, hazard_count, ex_dest, ex_RegWrite, stall);
    end
    @(negedge clk) rst_n = 1;
    drive_lw(5'd9);
    tick();
    drive_user(5'd9, 5'd10);
    #1;
    rst_n = 0;
    #1;
    rst_n = 1;
    drive_user(5'd9, 5'd15);
    tick();
    tests_run++;
    if (ex_valid !== 1 || ex_dest !== 5'd15 || hazard_count !== 0) begin
      tests_failed++;
      $display("FAIL reset_midstall: valid=%b dest=%0d cnt=%0d want 1 15 0", ex_valid, ex_dest, hazard_count);
    end
  endtask

  task automatic test_saturation();
    rst_n = 0;
    #2;
    rst_n = 1;
    clear_id();
    id_valid = 1; id_MemRead = 1; id_RegWrite = 1; id_dest = 5'd9; id_rs = 5'd9; id_use_rs = 1;
    for (int i = 0; i < 65535; i++) begin
      tick();
      tick();
    end
    tests_run++;
    if (hazard_count !== 16'hFFFF) begin
      tests_failed++; $display("FAIL sat_preload: cnt=%h want ffff", hazard_count);
    end
    tick();
    tests_run++;
    if (stall !== 1) begin
      tests_failed++; $display("FAIL sat_stall: stall=%b want 1", stall);
    end
    tick();
    tests_run++;
    if (hazard_count !== 16'hFFFF) begin
      tests_failed++; $display("FAIL sat_hold: cnt=%h want ffff", hazard_count);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_normal();
    test_regzero();
    test_load_use();
    test_no_false_hazard();
    test_flush();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 32, datapath width of operand, immediate and PC+4 fields.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of clk.
REQ-003 clk  input  1  system clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 id_valid  input  1  ID holds a real instruction.
REQ-006 id_pc4, id_rd1, id_rd2, id_imm  input  DATA_W each  PC+4, register-file read data 1/2, sign-extended immediate.
REQ-007 id_rs, id_rt  input  5 each  source register numbers.
REQ-008 id_dest  input  5  destination register chosen by the ID destination mux (rt / rd / return-address).
REQ-009 id_use_rs, id_use_rt  input  1 each  instruction actually reads rs / rt.
REQ-010 id_RegWrite, id_MemRead, id_MemWrite, id_ALUSrc  input  1 each  control bits.
REQ-011 id_MemtoReg  input  2  writeback select; id_ALUOp  input  4  ALU operation.
REQ-012 flush  input  1  branch/jump redirect; kill the instruction in ID.
REQ-013 ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc  output  1 each  registered EX copies.
REQ-014 ex_MemtoReg (2), ex_ALUOp (4), ex_rs (5), ex_rt (5), ex_dest (5), ex_pc4/ex_rd1/ex_rd2/ex_imm (DATA_W)  output  registered EX copies.
REQ-015 stall  output  1  combinational; freezes PC and IF/ID for the current cycle.
REQ-016 hazard_count  output  16  registered count of stall cycles.

Function
REQ-017 hazard SHALL be: id_valid & ex_valid & ex_MemRead & (ex_dest != 0) & ((id_use_rs & id_rs == ex_dest) | (id_use_rt & id_rt == ex_dest)).
REQ-018 stall SHALL equal hazard & ~flush, combinationally, in the same cycle.
REQ-019 Priority per rising edge: flush, then hazard, then normal load.
REQ-020 Flush or hazard edge SHALL load a bubble: ex_valid and all ex_ control outputs 0, ex_dest/ex_rs/ex_rt 0, data fields 0.
REQ-021 Normal edge SHALL load every ex_ field from its id_ counterpart, ex_valid <= id_valid, one-cycle latency.
REQ-022 ex_RegWrite SHALL load id_RegWrite & id_valid & (id_dest != 0); writes to register 0 never propagate.
REQ-023 ex_MemRead and ex_MemWrite SHALL load 0 when id_valid is 0.
REQ-024 A load-use pair SHALL produce exactly one stall cycle: after the bubble ex_valid=0 so hazard clears and the held ID instruction loads on the next edge.
REQ-025 hazard_count SHALL increment by 1 on each edge where stall=1 and saturate at 16'hFFFF (no wrap).
REQ-026 flush and hazard simultaneous: bubble loaded, stall=0, hazard_count unchanged.
REQ-027 A flush edge with no hazard SHALL not alter hazard_count.

Reset
REQ-028 rst_n low SHALL immediately, independent of clk, drive all ex_ outputs and hazard_count to 0; stall is then 0 because ex_valid=0.
REQ-029 Reset asserted mid-stall SHALL drop the in-flight instruction; first edge after rst_n rises performs a normal load.
REQ-030 rst_n deassertion SHALL take effect on the next rising clk edge with no extra latency.

Verification
REQ-031 Normal: id_valid=1, id_dest=5'd8, id_RegWrite=1, id_rd1=32'h1234 -> next edge ex_dest=8, ex_RegWrite=1, ex_rd1=32'h1234, stall=0.
REQ-032 Load-use: EX holds lw ex_dest=9, ex_MemRead=1; ID id_rs=9, id_use_rs=1 -> stall=1 that cycle, next edge ex_valid=0, hazard_count=1; following edge ID instruction loads, stall=0.
REQ-033 No false hazard: ex_MemRead=1, ex_dest=0, id_rs=0 -> stall=0; ex_dest=9, id_rt=9, id_use_rt=0 -> stall=0.
REQ-034 Flush priority: hazard condition plus flush=1 -> stall=0, bubble loaded, hazard_count unchanged.
REQ-035 Register zero: id_dest=0, id_RegWrite=1 -> ex_RegWrite=0; saturation: preload 16'hFFFF by 65535 stalls, one more stall -> hazard_count stays 16'hFFFF.
REQ-036 Async reset: assert rst_n=0 between edges while ex_valid=1, hazard_count=3 -> all outputs 0 before next edge.
